// File: rtl/serial_rx_fifo.sv
// Serial frame receiver (start, DATA_BITS LSB-first, parity, optional stop) feeding a FWFT FIFO.
// Define RX_STOP_CHECK_EN to add the stop-bit state and the stored framing-error flag.
module serial_rx_fifo #(
  parameter int unsigned DATA_BITS  = 7,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          serial_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_BITS-1:0]          out_data,
  output logic                          out_parity_err,
  output logic                          out_frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
`ifdef RX_STOP_CHECK_EN
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
`else
    S_PARITY = 2'd2
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_err_c;
  logic                 push_c;
  logic                 push_perr_c;
`ifdef RX_STOP_CHECK_EN
  logic                 perr_q;
  logic                 push_ferr_c;
`endif

  // Even parity flags a set XOR; odd parity inverts the sense.
  assign parity_err_c = (^shift_q) ^ serial_in ^ (PARITY_ODD != 0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    push_c      = 1'b0;
    push_perr_c = parity_err_c;
`ifdef RX_STOP_CHECK_EN
    push_ferr_c = 1'b0;
`endif
    case (state_q)
      S_IDLE:   if (!serial_in) state_d = S_DATA;
      S_DATA:   if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) state_d = S_PARITY;
      S_PARITY: begin
`ifdef RX_STOP_CHECK_EN
        state_d = S_STOP;
`else
        state_d = S_IDLE;
        push_c  = 1'b1;
`endif
      end
`ifdef RX_STOP_CHECK_EN
      S_STOP: begin
        state_d     = S_IDLE;
        push_c      = 1'b1;
        push_perr_c = perr_q;
        push_ferr_c = !serial_in;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Data capture: bit i of the frame lands directly in shift_q[i].
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
`ifdef RX_STOP_CHECK_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      if (state_q == S_IDLE) begin
        bit_cnt_q <= '0;
        shift_q   <= '0;
      end else if (state_q == S_DATA) begin
        shift_q[bit_cnt_q] <= serial_in;
        bit_cnt_q          <= bit_cnt_q + BIT_W'(1);
      end
`ifdef RX_STOP_CHECK_EN
      if (state_q == S_PARITY) perr_q <= parity_err_c;
`endif
    end
  end

  logic [DATA_BITS-1:0] mem_data [FIFO_DEPTH];
  logic                 mem_perr [FIFO_DEPTH];
`ifdef RX_STOP_CHECK_EN
  logic                 mem_ferr [FIFO_DEPTH];
`endif
  logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 full_c, pop_c, wr_c;

  assign full_c = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop_c  = (count_q != '0) && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign wr_c   = push_c && (!full_c || pop_c);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      overrun  <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_data[i] <= '0;
        mem_perr[i] <= 1'b0;
`ifdef RX_STOP_CHECK_EN
        mem_ferr[i] <= 1'b0;
`endif
      end
    end else begin
      overrun <= push_c && full_c && !pop_c;
      if (wr_c) begin
        mem_data[wr_ptr_q] <= shift_q;
        mem_perr[wr_ptr_q] <= push_perr_c;
`ifdef RX_STOP_CHECK_EN
        mem_ferr[wr_ptr_q] <= push_ferr_c;
`endif
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (wr_c && !pop_c)      count_q <= count_q + CNT_W'(1);
      else if (!wr_c && pop_c) count_q <= count_q - CNT_W'(1);
    end
  end

  assign out_valid      = (count_q != '0);
  assign fifo_count     = count_q;
  assign out_data       = mem_data[rd_ptr_q];
  assign out_parity_err = mem_perr[rd_ptr_q];
`ifdef RX_STOP_CHECK_EN
  assign out_frame_err  = mem_ferr[rd_ptr_q];
`else
  assign out_frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Self-checking bench for serial_rx_fifo: fixed vector table, corner sequences, random traffic vs a queue model.
module tb_serial_rx_fifo;

  localparam int DW    = 7;
  localparam int DEPTH = 4;
`ifdef RX_STOP_CHECK_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn, serial_in, out_ready;
  logic          out_valid, out_parity_err, out_frame_err, overrun;
  logic [DW-1:0] out_data;
  logic [2:0]    fifo_count;
  logic          o_valid, o_parity_err, o_frame_err, o_overrun;
  logic [DW-1:0] o_data;
  logic [2:0]    o_count;

  serial_rx_fifo #(.DATA_BITS(DW), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .serial_in(serial_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_parity_err(out_parity_err), .out_frame_err(out_frame_err),
    .overrun(overrun), .fifo_count(fifo_count));

  serial_rx_fifo #(.DATA_BITS(DW), .PARITY_ODD(1), .FIFO_DEPTH(DEPTH)) dut_odd (
    .clk(clk), .rstn(rstn), .serial_in(serial_in), .out_valid(o_valid), .out_ready(out_ready),
    .out_data(o_data), .out_parity_err(o_parity_err), .out_frame_err(o_frame_err),
    .overrun(o_overrun), .fifo_count(o_count));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          pe;
    logic          po;
    logic          fe;
  } ent_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          p;
    logic          s;
    logic [DW-1:0] xd;
    logic          xperr;
    logic          xferr;
  } vec_t;

  ent_t q[$];
  logic exp_ovr;
  int   checks = 0;
  int   errors = 0;
  int   ovr_seen = 0;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("valid", 32'(out_valid), 32'(q.size() != 0));
    chk("count", 32'(fifo_count), 32'(q.size()));
    chk("overrun", 32'(overrun), 32'(exp_ovr));
    chk("odd_count", 32'(o_count), 32'(q.size()));
    if (overrun) ovr_seen++;
    if (q.size() != 0) begin
      chk("head_data", 32'(out_data), 32'(q[0].d));
      chk("head_perr", 32'(out_parity_err), 32'(q[0].pe));
      chk("head_ferr", 32'(out_frame_err), 32'(q[0].fe));
      chk("odd_head_perr", 32'(o_parity_err), 32'(q[0].po));
    end
  endtask

  // One clock: drive inputs, advance the model by the spec's pop-then-push rules, compare.
  task automatic step(input logic sin, input logic rdy, input logic done, input ent_t e);
    logic full, pop;
    serial_in = sin;
    out_ready = rdy;
    full = (q.size() == DEPTH);
    pop  = rdy && (q.size() != 0);
    @(posedge clk);
    #1;
    exp_ovr = 1'b0;
    if (pop) void'(q.pop_front());
    if (done) begin
      if (full && !pop) exp_ovr = 1'b1;
      else q.push_back(e);
    end
    check_state();
  endtask

  function automatic logic rdy_for(input int mode, input logic last);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom_range(0, 1));
      default: return last;
    endcase
  endfunction

  // mode: 0 ready low, 1 ready high, 2 random ready, 3 ready only on the completion edge.
  task automatic frame(input logic [DW-1:0] d, input logic p, input logic s, input int mode);
    ent_t e;
    e.d  = d;
    e.pe = (^d) ^ p;
    e.po = !e.pe;
    e.fe = STOP_EN ? !s : 1'b0;
    step(1'b0, rdy_for(mode, 1'b0), 1'b0, e);
    for (int i = 0; i < DW; i++) step(d[i], rdy_for(mode, 1'b0), 1'b0, e);
`ifdef RX_STOP_CHECK_EN
    step(p, rdy_for(mode, 1'b0), 1'b0, e);
    step(s, rdy_for(mode, 1'b1), 1'b1, e);
`else
    step(p, rdy_for(mode, 1'b1), 1'b1, e);
`endif
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    serial_in = 1'b1;
    out_ready = 1'b0;
    #2;
    q.delete();
    exp_ovr = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_count", 32'(fifo_count), 32'(0));
    chk("rst_data", 32'(out_data), 32'(0));
    chk("rst_perr", 32'(out_parity_err), 32'(0));
    chk("rst_ferr", 32'(out_frame_err), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
    chk("rst_odd_count", 32'(o_count), 32'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] v, last;

    tbl[0] = '{d: 7'h55, p: 1'b0, s: 1'b1, xd: 7'h55, xperr: 1'b0, xferr: 1'b0};
    tbl[1] = '{d: 7'h55, p: 1'b1, s: 1'b1, xd: 7'h55, xperr: 1'b1, xferr: 1'b0};
    tbl[2] = '{d: 7'h2A, p: 1'b1, s: 1'b0, xd: 7'h2A, xperr: 1'b0, xferr: 1'b1};
    tbl[3] = '{d: 7'h7F, p: 1'b1, s: 1'b1, xd: 7'h7F, xperr: 1'b0, xferr: 1'b0};
    tbl[4] = '{d: 7'h00, p: 1'b1, s: 1'b1, xd: 7'h00, xperr: 1'b1, xferr: 1'b0};
    tbl[5] = '{d: 7'h11, p: 1'b0, s: 1'b0, xd: 7'h11, xperr: 1'b0, xferr: 1'b1};

    do_reset();

    // Single frames from the table, each from a fresh reset.
    foreach (tbl[i]) begin
      do_reset();
      frame(tbl[i].d, tbl[i].p, tbl[i].s, 0);
      chk("tbl_valid", 32'(out_valid), 32'(1));
      chk("tbl_count", 32'(fifo_count), 32'(1));
      chk("tbl_data", 32'(out_data), 32'(tbl[i].xd));
      chk("tbl_perr", 32'(out_parity_err), 32'(tbl[i].xperr));
      chk("tbl_ferr", 32'(out_frame_err), 32'(STOP_EN ? tbl[i].xferr : 1'b0));
      chk("tbl_odd_perr", 32'(o_parity_err), 32'(!tbl[i].xperr));
    end

    // Five back-to-back frames into a stalled consumer: one overrun, first four kept.
    do_reset();
    ovr_seen = 0;
    for (int k = 1; k <= 5; k++) begin
      v = DW'(k);
      frame(v, ^v, 1'b1, 0);
    end
    chk("ovr_count", 32'(fifo_count), 32'(4));
    step(1'b1, 1'b0, 1'b0, '0);
    chk("ovr_pulses", 32'(ovr_seen), 32'(1));
    for (int j = 0; j < 4; j++) begin
      chk("ovr_drain", 32'(out_data), 32'(j + 1));
      step(1'b1, 1'b1, 1'b0, '0);
    end
    chk("ovr_empty", 32'(out_valid), 32'(0));

    // Full FIFO, pop and push on the same edge.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      v = DW'(8'h10 + k);
      frame(v, ^v, 1'b1, 0);
    end
    frame(7'h7F, 1'b1, 1'b1, 3);
    chk("pp_count", 32'(fifo_count), 32'(4));
    chk("pp_overrun", 32'(overrun), 32'(0));
    last = '0;
    for (int j = 0; j < 4; j++) begin
      last = out_data;
      step(1'b1, 1'b1, 1'b0, '0);
    end
    chk("pp_last", 32'(last), 32'(7'h7F));

    // Reset during data bit 3 discards the partial frame.
    do_reset();
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    serial_in = 1'b0;
    do_reset();
    frame(7'h11, 1'b0, 1'b1, 0);
    for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 1'b0, '0);
    chk("mid_rst_count", 32'(fifo_count), 32'(1));
    chk("mid_rst_data", 32'(out_data), 32'(7'h11));

    // Random frames, gaps and consumer stalls against the queue model.
    do_reset();
    for (int n = 0; n < 80; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, '0);
      frame(DW'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), 2);
    end
    for (int j = 0; j < 8; j++) step(1'b1, 1'b1, 1'b0, '0);
    chk("final_empty", 32'(fifo_count), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_rx_fifo.md
# serial_rx_fifo

Parametrised serial frame receiver with a buffered output stage. It samples one bit per clock from `serial_in`: start bit, `DATA_BITS` data bits LSB first, one parity bit, and an optional stop bit. It checks parity (even or odd) and, optionally, framing. Each completed frame is pushed into an internal first-word-fall-through FIFO that drains through a valid/ready handshake. It sits between the serial line pins and the consuming logic, so back-to-back frames are accepted while the consumer stalls.

## Interface
Parameters:
- `DATA_BITS`, 7: data bits per frame, range 1..16.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity.
- `FIFO_DEPTH`, 4: number of FIFO entries; must be a power of two, at least 2.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rstn`  in  1: reset, asynchronous and active-low.
- `serial_in`  in  1: serial line; idles high.
- `out_valid`  out  1: FIFO not empty.
- `out_ready`  in  1: consumer accepts the head entry.
- `out_data`  out  `DATA_BITS`: data field of the head entry.
- `out_parity_err`  out  1: parity error flag of the head entry.
- `out_frame_err`  out  1: framing error flag of the head entry.
- `overrun`  out  1: one-cycle pulse when a completed frame is dropped because the FIFO is full.
- `fifo_count`  out  `$clog2(FIFO_DEPTH)+1`: number of valid entries, 0..`FIFO_DEPTH`.

## Operation
Receive FSM states are IDLE, DATA, PARITY and STOP. STOP exists only when `RX_STOP_CHECK_EN` is defined.
- **IDLE:** on an edge that samples `serial_in`=0, the start bit is taken; go to DATA with the bit counter at 0.
- **DATA:** shift `serial_in` in LSB first (the first data bit lands in bit 0). After `DATA_BITS` samples, go to PARITY.
- **PARITY:** sample the parity bit `p`. Let `x` = XOR of all data bits XOR `p`.
  - `PARITY_ODD`=0: parity error = `x`.
  - `PARITY_ODD`=1: parity error = !`x`.
  - Next state is STOP, or (without `RX_STOP_CHECK_EN`) the frame completes and the FSM goes to IDLE.
- **STOP:** sample the stop bit; framing error = !`serial_in`. The frame completes; go to IDLE.

Frame completion: the entry `{frame_err, parity_err, data}` is pushed on the same edge that samples the last bit of the frame.

FIFO behaviour:
- FIFO is first-word-fall-through: `out_data`, `out_parity_err` and `out_frame_err` always show the head entry. They hold their last value when the FIFO is empty; contents are don't-care.
- Pop happens when `out_valid` && `out_ready`.
- Push and pop on the same edge: both happen and `fifo_count` is unchanged. This also applies when the FIFO is full: the pop frees a slot and the push is accepted, with no overrun.
- Push while full with no pop: the frame is dropped and `overrun`=1 for the next cycle only. FIFO contents are unchanged.
- Read and write pointers wrap modulo `FIFO_DEPTH`.
- Frames with parity or framing errors are still pushed, with their flags set; they are never discarded.

Reset:
- Asserting `rstn` low at any time, including mid-frame, forces IDLE, discards any partial frame and empties the FIFO.
- Reset values: `out_valid`=0, `out_data`=0, `out_parity_err`=0, `out_frame_err`=0, `overrun`=0, `fifo_count`=0.

## Timing
- Start bit sampled at edge T. Data bit i is sampled at edge T+1+i. Parity bit is sampled at edge T+`DATA_BITS`+1. Stop bit (macro defined) is sampled at edge T+`DATA_BITS`+2.
- `out_valid` and the updated `fifo_count` are visible immediately after the completion edge, i.e. zero-cycle push-to-valid latency.
- Back-to-back frames: IDLE is active on the edge after completion, so the next start bit may be sampled at completion edge +1. There is no inter-frame gap.
- Frame period is `DATA_BITS`+3 cycles with `RX_STOP_CHECK_EN`, and `DATA_BITS`+2 cycles without it.
- A pop takes effect on the edge where `out_valid` && `out_ready`. The next entry appears after that edge.
- `out_valid` depends only on registered state, never combinationally on `out_ready`.

## Configuration
- `RX_STOP_CHECK_EN`, when defined:
  - the STOP state is present;
  - each frame carries one stop bit, expected to be 1;
  - `out_frame_err` is the stored flag from the stop-bit check.
- When undefined:
  - there is no STOP state and the frame ends after the parity bit;
  - `out_frame_err` is tied to 0;
  - no frame-error storage bit exists in the FIFO.

## Test plan
1. **Single good frame.** Defaults, macro defined. Send 0 (start), data bits 1,0,1,0,1,0,1 (0x55), parity 0, stop 1 → `out_valid`=1 after the stop edge, `out_data`=0x55, both error flags 0, `fifo_count`=1.
2. **Parity error.** Same as scenario 1 but parity bit 1 → `out_data`=0x55, `out_parity_err`=1. Repeat with `PARITY_ODD`=1 and parity bit 1 → `out_parity_err`=0.
3. **Framing error.** Send 0x2A with correct parity 1 and stop bit 0 → `out_data`=0x2A, `out_frame_err`=1, `out_parity_err`=0.
4. **Overrun.** Hold `out_ready`=0 and send 5 back-to-back frames 0x01..0x05 with no gaps → `fifo_count`=4, `overrun` pulses once after frame 5. Draining then yields 0x01,0x02,0x03,0x04 in order.
5. **Push and pop when full.** With the FIFO full and `out_ready`=1 on the completion edge of a new frame 0x7F → no overrun, `fifo_count` stays 4, and 0x7F is the last entry read out.
6. **Reset mid-frame.** Pulse `rstn` low during data bit 3, then send a full frame 0x11 → only 0x11 is received and `fifo_count`=1. Also repeat scenario 1 with the macro undefined → `out_valid` rises one cycle earlier and `out_frame_err`=0.
